// File: rtl/mem_access_stage_pkg.sv
// riscv_pkg: shared types and constants for the MEM stage.
//   XLEN, REG_ADDR_W   - default datapath / register index widths
//   mem_state_e        - MEM stage FSM states
//   F3_*               - load/store funct3 access size/sign encodings
//   is_misaligned()    - alignment rule used when MEM_MISALIGN_CHECK_EN is set
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need addr[0]=0; words (and undefined sizes, which are
  // treated as words) need addr[1:0]=0. Bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return off[0];
      default:     return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational byte-lane steering for data memory.
//   funct3     in  3  : access size/sign
//   off        in  2  : addr[1:0]
//   store_data in  32 : rs2 value
//   load_data  in  32 : raw word from memory
//   be         out 4  : byte enables
//   wdata      out 32 : store data replicated across lanes
//   lmd        out 32 : extracted and extended load data
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] lmd
);

  logic [31:0] shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign shifted   = load_data >> {off, 3'b000};
  assign lane_byte = shifted[7:0];
  assign lane_half = off[1] ? load_data[31:16] : load_data[15:0];

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    lmd   = load_data;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
        lmd   = (funct3 == F3_B) ? {{24{lane_byte[7]}}, lane_byte}
                                 : {24'b0, lane_byte};
      end
      F3_H, F3_HU: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
        lmd   = (funct3 == F3_H) ? {{16{lane_half[15]}}, lane_half}
                                 : {16'b0, lane_half};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
        lmd   = load_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage between execute and writeback.
// Accepts one instruction when ex_valid & ex_ready, issues loads/stores
// over a req/gnt/rvalid data-memory handshake and retires each
// instruction with a one-cycle wb_valid pulse.
//   clk, rst_n           : clock, synchronous active-low reset
//   ex_*                 : instruction fields from execute; ex_ready stalls it
//   dmem_*               : data memory request / grant / response
//   condpc               : next PC, registered at accept
//   wb_*                 : MEM/WB register fields
//   misalign_exc         : only when MEM_MISALIGN_CHECK_EN is defined
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [DATA_WIDTH-1:0] ex_npc,
  input  logic                  ex_cond,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] condpc,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_lmd,
  output logic [DATA_WIDTH-1:0] wb_alu_result,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_exc
`endif
);

  mem_state_e            state;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] store_data_q;
  logic [2:0]            funct3_q;
  logic                  mem_write_q;
  logic                  misalign_now;
  logic                  mem_op;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] lane_lmd;

  assign mem_op = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_now = mem_op & is_misaligned(ex_funct3, ex_alu_result[1:0]);
`else
  assign misalign_now = 1'b0;
`endif

  mem_lane_align u_lane (
    .funct3     (funct3_q),
    .off        (alu_q[1:0]),
    .store_data (store_data_q),
    .load_data  (dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .lmd        (lane_lmd)
  );

  assign ex_ready = (state == IDLE);

  // Request-side outputs are forced to zero outside REQ so the bus is
  // quiet after reset and between transactions.
  assign dmem_req   = (state == REQ);
  assign dmem_we    = dmem_req & mem_write_q;
  assign dmem_addr  = dmem_req ? {alu_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dmem_wdata = dmem_req ? lane_wdata : '0;
  assign dmem_be    = dmem_req ? lane_be : '0;

  assign wb_alu_result = alu_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      alu_q         <= '0;
      store_data_q  <= '0;
      funct3_q      <= '0;
      mem_write_q   <= 1'b0;
      condpc        <= '0;
      wb_valid      <= 1'b0;
      wb_lmd        <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_exc  <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_exc <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ex_valid) begin
            alu_q         <= ex_alu_result;
            store_data_q  <= ex_store_data;
            funct3_q      <= ex_funct3;
            mem_write_q   <= ex_mem_write;
            condpc        <= ex_cond ? ex_alu_result : ex_npc;
            wb_rd         <= ex_rd;
            wb_mem_to_reg <= ex_mem_to_reg;
            // Register-write suppression for stores and faulting accesses
            // is resolved at accept so the retire paths need no extra mux.
            wb_reg_write  <= ex_reg_write & ~ex_mem_write & ~misalign_now;
            if (misalign_now) begin
              wb_valid <= 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
              misalign_exc <= 1'b1;
`endif
            end else if (mem_op) begin
              state <= REQ;
            end else begin
              wb_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            if (mem_write_q) begin
              wb_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (dmem_rvalid) begin
            wb_lmd   <= lane_lmd;
            wb_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage between execute and writeback. Accepts one instruction at a time from execute and issues loads and stores to data memory over a request/grant/response handshake. It produces the load memory data (LMD), the conditional next PC (condpc) and the MEM/WB register fields consumed by writeback. It stalls execute through `ex_ready` while a memory transaction is outstanding.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath and address width (from `riscv_pkg`)
- `REG_ADDR_W`, 5, destination register index width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `ex_valid` in 1: execute presents an instruction
- `ex_ready` out 1: stage accepts this cycle; accept = `ex_valid & ex_ready`
- `ex_alu_result` in DATA_WIDTH: ALU output; the address for loads/stores
- `ex_store_data` in DATA_WIDTH: rs2 value for stores
- `ex_npc` in DATA_WIDTH: PC+4
- `ex_cond` in 1: branch/jump taken
- `ex_mem_read`, `ex_mem_write` in 1 each: load / store
- `ex_funct3` in 3: access size/sign
- `ex_rd` in REG_ADDR_W, `ex_reg_write` in 1, `ex_mem_to_reg` in 1: writeback control
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out DATA_WIDTH (word-aligned), `dmem_wdata` out DATA_WIDTH, `dmem_be` out 4: memory request
- `dmem_gnt` in 1: request accepted
- `dmem_rvalid` in 1, `dmem_rdata` in DATA_WIDTH: load response
- `condpc` out DATA_WIDTH: next PC
- `wb_valid` out 1: one-cycle pulse per retired instruction
- `wb_lmd`, `wb_alu_result` out DATA_WIDTH; `wb_rd` out REG_ADDR_W; `wb_reg_write`, `wb_mem_to_reg` out 1
- `misalign_exc` out 1: present only with `MEM_MISALIGN_CHECK_EN`

## Operation
- FSM states: IDLE, REQ, WAIT_RSP. `ex_ready` = 1 only in IDLE.
- **IDLE, accept:**
  - Latch all `ex_*` fields.
  - Register `condpc` = `ex_cond ? ex_alu_result : ex_npc`.
  - Load or store goes to REQ.
  - Otherwise retire next cycle and stay in IDLE.
- **REQ:**
  - `dmem_req`=1; `dmem_we`=stored op is a store; address is `{alu[31:2],2'b00}`.
  - Held stable until `dmem_gnt`.
  - On `gnt`: a store retires next cycle and goes to IDLE; a load goes to WAIT_RSP.
- **WAIT_RSP:** on `dmem_rvalid`, capture the extracted/extended data into `wb_lmd`, retire next cycle, go to IDLE. `dmem_rvalid` in other states is ignored.
- **Retire:**
  - `wb_valid`=1 for one cycle with the latched rd/reg_write/mem_to_reg/alu_result.
  - Stores force `wb_reg_write`=0.
  - `wb_lmd` holds its value between loads.
- **Lanes (offset = addr[1:0]):**
  - SB: be=0001<<off, wdata=byte replicated ×4.
  - SH: be=0011<<(addr[1]*2), wdata=half replicated ×2.
  - SW: be=1111.
  - LB/LBU: byte at lane off, sign-/zero-extended. LH/LHU: half at addr[1]. LW: full word.
  - Undefined funct3 is treated as a word access.
- **Reset:** synchronous; state IDLE, aborts any outstanding transaction.
  - After reset, all outputs are 0: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `condpc`, `wb_*`, `misalign_exc`.
  - `ex_ready`=1 after reset.
  - A late `rvalid` after reset is ignored.

## Timing
- Accept at cycle N for a non-memory instruction: `wb_valid` at N+1.
- Store: `dmem_req` from N+1; `gnt` at cycle G; `wb_valid` at G+1. Best case N+2.
- Load: `gnt` at G; `rvalid` at R≥G+1; `wb_valid` at R+1. Best case N+3.
- `condpc` is valid from N+1 and held until the next accept.
- `ex_ready` deasserts at N+1 for memory ops and reasserts in the cycle `wb_valid` pulses. Back-to-back non-memory ops run at one per cycle.
- Writeback never stalls; `wb_valid` is not handshaked.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - Check: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - On a misaligned access, no `dmem_req` is issued. Retire at N+1 with `wb_valid`=1, `wb_reg_write`=0 and `misalign_exc`=1 for that cycle only.
- Undefined: no check and no `misalign_exc` port. The low address bits are truncated per the lane rules above.

## Structure
- `riscv_pkg` gains:
  - `mem_state_e` (IDLE, REQ, WAIT_RSP)
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
- Sub-module `mem_lane_align`: combinational; computes `dmem_be`, the store data shift and the load extract/extend from funct3 and addr[1:0]. The stage instantiates it once.

## Test plan
- ALU op, alu=0x0000_0010, cond=0, npc=0x104, rd=5 → `wb_valid` at N+1, `wb_alu_result`=0x10, `condpc`=0x104, `ex_ready` stays 1.
- SB to 0x1003, data=0xAB, `gnt` at N+1 → `dmem_addr`=0x1000, `dmem_be`=1000, `dmem_wdata`=0xABABABAB; `wb_valid` at N+2 with `reg_write`=0.
- LB from 0x2001, `gnt` delayed 2 cycles, `rdata`=0x00008000 then 0x0000_8000 lane1 → `wb_lmd`=0xFFFF_FF80; LBU gives 0x80; `ex_ready` low throughout.
- LW with `gnt` at N+1 and `rvalid` at N+4 while execute holds `ex_valid` → exactly one accept; `wb_valid` at N+5, `wb_lmd`=`rdata`.
- `rst_n`=0 during WAIT_RSP, then `rvalid` arrives → all outputs 0, no `wb_valid`, IDLE, `ex_ready`=1.
- With `MEM_MISALIGN_CHECK_EN`: LW at 0x3002 → no `dmem_req`, `wb_valid`=`misalign_exc`=1 at N+1, `wb_reg_write`=0.
